// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and constants for the round-robin memory controller.
package mem_ctrl_pkg;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic LSB    = 1'b0;
    localparam logic ICACHE = 1'b1;

    localparam logic [31:0] UART_DATA_ADDR = 32'h0003_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h0003_0004;

    // Width code 3 is illegal and behaves as a word access.
    function automatic logic [2:0] byte_count(logic [1:0] width);
        case (width)
            W_BYTE:  return 3'd1;
            W_HALF:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_rr_if.sv
// RAM bus plus ICache and LSB request/response channels of the memory controller.
interface mem_ctrl_rr_if #(
    parameter int unsigned BLOCK_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH  = 32
);
    logic [7:0]                    RAMMC_data;
    logic [7:0]                    MCRAM_data;
    logic [ADDR_WIDTH-1:0]         MCRAM_addr;
    logic                          MCRAM_wr;

    logic                          ICMC_en;
    logic [ADDR_WIDTH-1:0]         ICMC_addr;
    logic                          MCIC_en;
    logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block;

    logic                          LSBMC_en;
    logic                          LSBMC_wr;
    logic [1:0]                    LSBMC_width;
    logic [31:0]                   LSBMC_data;
    logic [ADDR_WIDTH-1:0]         LSBMC_addr;
    logic                          MCLSB_en;
    logic [31:0]                   MCLSB_data;

    modport slave (
        input  RAMMC_data, ICMC_en, ICMC_addr,
        input  LSBMC_en, LSBMC_wr, LSBMC_width, LSBMC_data, LSBMC_addr,
        output MCRAM_data, MCRAM_addr, MCRAM_wr,
        output MCIC_en, MCIC_block, MCLSB_en, MCLSB_data
    );

    modport master (
        output RAMMC_data, ICMC_en, ICMC_addr,
        output LSBMC_en, LSBMC_wr, LSBMC_width, LSBMC_data, LSBMC_addr,
        input  MCRAM_data, MCRAM_addr, MCRAM_wr,
        input  MCIC_en, MCIC_block, MCLSB_en, MCLSB_data
    );

endinterface

// File: rtl/mc_rr_arbiter.sv
// Two-way round-robin grant between ICache and LSB with done-cycle cooldown
// and UART-full masking; only last_serve is stateful.
module mc_rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_0  = ADDR_WIDTH'(UART_DATA_ADDR),
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_1  = ADDR_WIDTH'(UART_STAT_ADDR)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rdy_i,
    input  logic                  idle_i,
    input  logic                  flush_i,
    input  logic                  io_full_i,
    input  logic                  ic_en_i,
    input  logic                  ic_done_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    input  logic                  lsb_en_i,
    input  logic                  lsb_done_i,
    input  logic [ADDR_WIDTH-1:0] lsb_addr_i,
    output logic                  gnt_ic_o,
    output logic                  gnt_lsb_o
);

    logic last_q;
    logic ic_req, lsb_req;
    logic ic_io_stall, lsb_io_stall;

    assign ic_io_stall  = io_full_i && (ic_addr_i == IO_ADDR_0 || ic_addr_i == IO_ADDR_1);
    assign lsb_io_stall = io_full_i && (lsb_addr_i == IO_ADDR_0 || lsb_addr_i == IO_ADDR_1);

    // A requester whose done pulse is still high is masked so it cannot be served twice.
    assign ic_req  = ic_en_i && !ic_done_i && !flush_i && !ic_io_stall;
    assign lsb_req = lsb_en_i && !lsb_done_i && !lsb_io_stall;

    assign gnt_ic_o  = idle_i && ic_req && (!lsb_req || last_q == LSB);
    assign gnt_lsb_o = idle_i && lsb_req && !gnt_ic_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= LSB;
        end else if (rdy_i && (gnt_ic_o || gnt_lsb_o)) begin
            last_q <= gnt_ic_o ? ICACHE : LSB;
        end
    end

endmodule

// File: rtl/mem_ctrl_rr.sv
// Byte-wide RAM controller serving ICache block refills and LSB loads/stores
// with pipelined one-cycle-latency reads and round-robin arbitration.
module mem_ctrl_rr
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned           BLOCK_WIDTH = 1,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_0   = ADDR_WIDTH'(UART_DATA_ADDR),
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_1   = ADDR_WIDTH'(UART_STAT_ADDR)
) (
    input  logic         Sys_clk,
    input  logic         Sys_rst_n,
    input  logic         Sys_rdy,
    input  logic         Sys_flush,
    input  logic         io_buffer_full,
    mem_ctrl_rr_if.slave bus
);

    localparam int unsigned CW = BLOCK_WIDTH + 3;
    localparam int unsigned BW = 32 << BLOCK_WIDTH;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t IC_BYTES = cnt_t'(4 << BLOCK_WIDTH);

    logic [1:0]            state_q, state_d;
    logic                  serve_q, serve_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    cnt_t                  nbytes_q, nbytes_d, issue_q, issue_d, cap_q, cap_d;
    logic [1:0]            vld_q, vld_d;
    logic                  wr_q, wr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [31:0]           st_q, st_d, ld_q, ld_d, lsb_data_q, lsb_data_d;
    logic [BW-1:0]         block_q, block_d;
    logic                  ic_done_q, ic_done_d, lsb_done_q, lsb_done_d;
    logic                  rdy_q;
    logic [7:0]            skid_q, rd_byte;
    logic                  gnt_ic, gnt_lsb;

    mc_rr_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IO_ADDR_0  (IO_ADDR_0),
        .IO_ADDR_1  (IO_ADDR_1)
    ) u_arb (
        .clk_i      (Sys_clk),
        .rst_ni     (Sys_rst_n),
        .rdy_i      (Sys_rdy),
        .idle_i     (state_q == IDLE),
        .flush_i    (Sys_flush),
        .io_full_i  (io_buffer_full),
        .ic_en_i    (bus.ICMC_en),
        .ic_done_i  (ic_done_q),
        .ic_addr_i  (bus.ICMC_addr),
        .lsb_en_i   (bus.LSBMC_en),
        .lsb_done_i (lsb_done_q),
        .lsb_addr_i (bus.LSBMC_addr),
        .gnt_ic_o   (gnt_ic),
        .gnt_lsb_o  (gnt_lsb)
    );

    // The RAM keeps reading the held address while stalled, so the byte due at the
    // first stalled edge is parked and replayed on resume.
    assign rd_byte = rdy_q ? bus.RAMMC_data : skid_q;

    always_comb begin
        state_d    = state_q;
        serve_d    = serve_q;
        base_d     = base_q;
        addr_d     = addr_q;
        nbytes_d   = nbytes_q;
        issue_d    = issue_q;
        cap_d      = cap_q;
        vld_d      = vld_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        st_d       = st_q;
        ld_d       = ld_q;
        lsb_data_d = lsb_data_q;
        block_d    = block_q;
        ic_done_d  = 1'b0;
        lsb_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d  = '0;
                wr_d    = 1'b0;
                wdata_d = '0;
                if (gnt_ic || gnt_lsb) begin
                    issue_d = cnt_t'(1);
                    cap_d   = '0;
                    vld_d   = 2'b01;
                    if (gnt_ic) begin
                        serve_d  = ICACHE;
                        base_d   = bus.ICMC_addr;
                        addr_d   = bus.ICMC_addr;
                        nbytes_d = IC_BYTES;
                        state_d  = READ;
                    end else begin
                        serve_d  = LSB;
                        base_d   = bus.LSBMC_addr;
                        addr_d   = bus.LSBMC_addr;
                        nbytes_d = cnt_t'(byte_count(bus.LSBMC_width));
                        ld_d     = '0;
                        if (bus.LSBMC_wr) begin
                            state_d = WRITE;
                            wr_d    = 1'b1;
                            wdata_d = bus.LSBMC_data[7:0];
                            st_d    = bus.LSBMC_data;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (Sys_flush && serve_q == ICACHE) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    wr_d    = 1'b0;
                end else begin
                    vld_d = {vld_q[0], 1'b0};
                    if (issue_q < nbytes_q) begin
                        addr_d   = base_q + ADDR_WIDTH'(issue_q);
                        issue_d  = issue_q + cnt_t'(1);
                        vld_d[0] = 1'b1;
                    end
                    if (vld_q[1]) begin
                        cap_d = cap_q + cnt_t'(1);
                        if (serve_q == ICACHE) begin
                            block_d[{cap_q[CW-2:0], 3'b000} +: 8] = rd_byte;
                        end else begin
                            ld_d[{cap_q[1:0], 3'b000} +: 8] = rd_byte;
                        end
                        if (cap_q == nbytes_q - cnt_t'(1)) begin
                            state_d = IDLE;
                            addr_d  = '0;
                            if (serve_q == ICACHE) begin
                                ic_done_d = 1'b1;
                            end else begin
                                lsb_done_d = 1'b1;
                                lsb_data_d = ld_d;
                            end
                        end
                    end
                end
            end
            WRITE: begin
                if (issue_q == nbytes_q) begin
                    state_d    = IDLE;
                    addr_d     = '0;
                    wr_d       = 1'b0;
                    wdata_d    = '0;
                    lsb_done_d = 1'b1;
                end else begin
                    addr_d  = base_q + ADDR_WIDTH'(issue_q);
                    wdata_d = st_q[{issue_q[1:0], 3'b000} +: 8];
                    issue_d = issue_q + cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            state_q    <= IDLE;
            serve_q    <= LSB;
            base_q     <= '0;
            addr_q     <= '0;
            nbytes_q   <= '0;
            issue_q    <= '0;
            cap_q      <= '0;
            vld_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            st_q       <= '0;
            ld_q       <= '0;
            lsb_data_q <= '0;
            block_q    <= '0;
            ic_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
        end else if (Sys_rdy) begin
            state_q    <= state_d;
            serve_q    <= serve_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            issue_q    <= issue_d;
            cap_q      <= cap_d;
            vld_q      <= vld_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            st_q       <= st_d;
            ld_q       <= ld_d;
            lsb_data_q <= lsb_data_d;
            block_q    <= block_d;
            ic_done_q  <= ic_done_d;
            lsb_done_q <= lsb_done_d;
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            rdy_q  <= 1'b0;
            skid_q <= '0;
        end else begin
            rdy_q <= Sys_rdy;
            if (rdy_q && !Sys_rdy) skid_q <= bus.RAMMC_data;
        end
    end

    assign bus.MCRAM_addr = addr_q;
    assign bus.MCRAM_wr   = wr_q;
    assign bus.MCRAM_data = wdata_q;
    assign bus.MCIC_en    = ic_done_q;
    assign bus.MCIC_block = block_q;
    assign bus.MCLSB_en   = lsb_done_q;
    assign bus.MCLSB_data = lsb_data_q;

endmodule
